cmp_slice_accum: RTL and testbench

- Downstream stage of the 2-bit magnitude comparator: consumes its per-slice outputs (abigger/asmaller/same).
- Slices are presented MSB-first, one per cycle, with a valid strobe.
- Accumulates them into a single N-bit comparison result (NUM_SLICES*2 bits per operand).
- Reports the result with a done pulse and holds it until the next start.

---
 rtl/cmp_pkg.sv | 18 +
 rtl/cmp_onehot_chk.sv | 15 +
 rtl/cmp_slice_accum.sv | 116 +++++++++++
 tb/tb_cmp_slice_accum.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the slice-serial magnitude comparator accumulator.
package cmp_pkg;

    localparam int CMP_SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    typedef struct packed {
        logic abigger;
        logic asmaller;
        logic same;
    } cmp_res_t;

endpackage

// File: rtl/cmp_onehot_chk.sv
// Flags whether a 3-bit per-slice comparator result is exactly one-hot.
module cmp_onehot_chk (
    input  logic [2:0] bits,
    output logic       onehot_ok
);

    always_comb begin
        onehot_ok = 1'b0;
        case (bits)
            3'b001, 3'b010, 3'b100: onehot_ok = 1'b1;
            default:                onehot_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp_slice_accum.sv
// Folds MSB-first 2-bit slice comparisons into one wide A-vs-B result.
// Optional macro CMP_EARLY_EXIT_EN finishes on the first deciding slice.
module cmp_slice_accum
    import cmp_pkg::*;
#(
    parameter int NUM_SLICES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic slice_vld,
    input  logic abigger,
    input  logic asmaller,
    input  logic same,
    output logic busy,
    output logic done,
    output logic res_abigger,
    output logic res_asmaller,
    output logic res_same,
    output logic err
);

    localparam int CNT_W = $clog2(NUM_SLICES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SLICES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic             decided, decided_n;
    cmp_res_t         res_q, res_n;
    logic             err_n;
    logic             onehot_ok;
    logic             deciding;

    cmp_onehot_chk u_onehot_chk (
        .bits      ({abigger, asmaller, same}),
        .onehot_ok (onehot_ok)
    );

    // The first non-equal slice (most significant) fixes the outcome.
    assign deciding = !decided && (abigger || asmaller);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            decided <= 1'b0;
            res_q   <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            decided <= decided_n;
            res_q   <= res_n;
            err     <= err_n;
            busy    <= (state_n == ACCUM);
            done    <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        decided_n = decided;
        res_n     = res_q;
        err_n     = err;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start) begin
                    state_n   = ACCUM;
                    count_n   = '0;
                    decided_n = 1'b0;
                    res_n     = '0;
                    err_n     = 1'b0;
                end
            end
            ACCUM: begin
                if (slice_vld) begin
                    if (!onehot_ok) begin
                        err_n   = 1'b1;
                        res_n   = '0;
                        state_n = DONE;
                    end else begin
                        if (deciding) begin
                            decided_n      = 1'b1;
                            res_n.abigger  = abigger;
                            res_n.asmaller = asmaller;
                        end
                        // Count is held on the final slice rather than wrapping.
                        if (count == LAST_IDX) begin
                            state_n = DONE;
                            if (!decided && same) begin
                                res_n.same = 1'b1;
                            end
                        end else begin
                            count_n = count + 1'b1;
                        end
`ifdef CMP_EARLY_EXIT_EN
                        if (deciding) begin
                            state_n = DONE;
                        end
`endif
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign res_abigger  = res_q.abigger;
    assign res_asmaller = res_q.asmaller;
    assign res_same     = res_q.same;

endmodule

// File: tb/tb_cmp_slice_accum.sv
// Scoreboard bench for cmp_slice_accum (NUM_SLICES=4): stimulus queues expected
// results and done cycles, a monitor checks them whenever done is seen.
module tb_cmp_slice_accum;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic start;
    logic slice_vld;
    logic abigger;
    logic asmaller;
    logic same;
    logic busy;
    logic done;
    logic res_abigger;
    logic res_asmaller;
    logic res_same;
    logic err;

    typedef struct {
        logic [3:0] res;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   tests = 0;
    int   fails = 0;

    cmp_slice_accum #(.NUM_SLICES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .slice_vld    (slice_vld),
        .abigger      (abigger),
        .asmaller     (asmaller),
        .same         (same),
        .busy         (busy),
        .done         (done),
        .res_abigger  (res_abigger),
        .res_asmaller (res_asmaller),
        .res_same     (res_same),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t       e;
            logic [3:0] got;
            got = {res_abigger, res_asmaller, res_same, err};
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, required no done", cycle);
            end else begin
                e = sb.pop_front();
                if (got !== e.res || cycle != e.cyc) begin
                    fails++;
                    $display("[TB] FAIL done_result: got {big,small,same,err}=%b at cycle %0d, required %b at cycle %0d",
                             got, cycle, e.res, e.cyc);
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [5:0] got, input logic [5:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got {busy,done,big,small,same,err}=%b, required %b", name, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {busy, done, res_abigger, res_asmaller, res_same, err};
    endfunction

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s_timeout: got %0d pending results, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic issue_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // slices[11:9] is the MSB slice, each as {abigger,asmaller,same}.
    task automatic apply_stimulus(input string name, input logic [11:0] slices, input int final_idx,
                                  input logic [3:0] exp, input int gap_at, input int pulse_at);
        for (int i = 0; i < 4; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < 2; g++) begin
                    @(negedge clk);
                    slice_vld = 1'b0;
                    check_output("busy_in_gap", {busy, 5'b0}, 6'b100000);
                end
            end
            if (i == pulse_at) begin
                @(negedge clk);
                slice_vld = 1'b0;
                start     = 1'b1;
            end
            @(negedge clk);
            start     = 1'b0;
            slice_vld = 1'b1;
            {abigger, asmaller, same} = slices[11-3*i -: 3];
            if (i == final_idx) sb.push_back('{exp, cycle + 1});
        end
        @(negedge clk);
        slice_vld = 1'b0;
        {abigger, asmaller, same} = 3'b000;
        wait_drain(name);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        slice_vld = 1'b0;
        abigger   = 1'b0;
        asmaller  = 1'b0;
        same      = 1'b0;
        #1;
        check_output("reset_state", outs(), 6'b000000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // A=B4, B=B1: decided by the third slice, fourth slice ignored.
        issue_start();
        apply_stimulus("b4_vs_b1", 12'b001_001_100_010, EARLY ? 2 : 3, 4'b1000, -1, -1);
        repeat (2) @(negedge clk);
        check_output("result_hold", outs(), 6'b001000);

        // A=B=5A with a two-cycle gap after slice 2.
        issue_start();
        apply_stimulus("equal_gap", 12'b001_001_001_001, 3, 4'b0010, 2, -1);

        // Slice 2 not one-hot: error ends the run early.
        issue_start();
        apply_stimulus("err_slice", 12'b001_110_001_001, 1, 4'b0001, -1, -1);
        @(negedge clk);
        check_output("err_sticky", outs(), 6'b000001);
        issue_start();
        check_output("err_cleared", outs(), 6'b100000);
        apply_stimulus("after_err", 12'b010_001_001_001, EARLY ? 0 : 3, 4'b0100, -1, -1);

        // Reset in the middle of a run: abandoned, no done pulse.
        issue_start();
        @(negedge clk);
        slice_vld = 1'b1;
        {abigger, asmaller, same} = 3'b001;
        @(negedge clk);
        @(negedge clk);
        slice_vld = 1'b0;
        {abigger, asmaller, same} = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset", outs(), 6'b000000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue_start();
        apply_stimulus("after_reset", 12'b100_010_001_001, EARLY ? 0 : 3, 4'b1000, -1, -1);

        // First slice decides (early exit only when the macro is defined).
        issue_start();
        apply_stimulus("first_smaller", 12'b010_100_001_001, EARLY ? 0 : 3, 4'b0100, -1, -1);

        // Slice coinciding with start in IDLE is dropped; start in ACCUM ignored.
        @(negedge clk);
        start     = 1'b1;
        slice_vld = 1'b1;
        {abigger, asmaller, same} = 3'b100;
        @(negedge clk);
        start     = 1'b0;
        slice_vld = 1'b0;
        {abigger, asmaller, same} = 3'b000;
        apply_stimulus("start_with_vld", 12'b001_001_001_010, 3, 4'b0100, -1, 2);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
